multi_way_traffic_lights: RTL and testbench
===========================================

Name: multi_way_traffic_lights

Overview:
- Parametrised successor to the two-way junction controller.
- Sequences NUM_WAYS approaches through red+amber, green, amber and all-red clearance, one approach non-red at a time.
- Per-phase durations are parameters.
- Adds an optional demand-actuated mode (approaches with no request are skipped), a run-enable hold and a flashing-amber fault/night mode.
- Sits at junction top level and drives lamp drivers directly.

Parameters:
- NUM_WAYS, 4, number of approaches, 2..8.
- RA_CYCLES, 2, red+amber phase length in clocks, >=1.
- GREEN_CYCLES, 8, green phase length, >=1.
- AMBER_CYCLES, 3, amber phase length, >=1.
- ALLRED_CYCLES, 2, all-red clearance length, >=1.
- FLASH_CYCLES, 4, half-period of flashing amber, >=1.
- DEMAND_MODE, 0, 0 = fixed round-robin; 1 = serve only requested ways.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  1 = run; 0 = freeze timer, phase and way (outputs hold).
- flash  in  1  1 = flashing-amber mode; overrides en.
- req  in  NUM_WAYS  per-way vehicle-detector request, level, synchronous.
- lights  out  3*NUM_WAYS  way i at [3i+2:3i]; bit2 red, bit1 amber, bit0 green.
- active_way  out  $clog2(NUM_WAYS)  way currently owning the non-red sequence.
- phase  out  2  0 ALL_RED, 1 RED_AMBER, 2 GREEN, 3 AMBER.

Behaviour:
- State: phase reg, way reg, down-counter timer sized for the largest cycle parameter, pending[NUM_WAYS], flash counter, flash_on bit.
- All outputs are decoded combinationally from registered state only; no input-to-output path.
- Reset (async, any time, including mid-phase or during flash):
  - phase = ALL_RED, way = NUM_WAYS-1, timer = ALLRED_CYCLES.
  - pending = 0, flash counter = 0.
  - lights = all ways 3'b100.
- Lamp decode, normal mode:
  - Non-active ways: 3'b100.
  - Active way by phase: ALL_RED 100, RED_AMBER 110, GREEN 001, AMBER 010.
- Phase order: ALL_RED -> RED_AMBER -> GREEN -> AMBER -> ALL_RED.
  - Each phase lasts exactly its parameter in enabled cycles: timer loads N on entry, decrements each enabled cycle, and the phase advances on the cycle timer==1.
  - On entry to RED_AMBER, way takes the selected next way.
- Next-way selection at the end of ALL_RED:
  - DEMAND_MODE=0: (way+1) mod NUM_WAYS. Wrap from NUM_WAYS-1 goes to 0.
  - DEMAND_MODE=1: first set bit of pending scanning way+1, way+2, ... and finally way itself (round-robin).
  - If pending==0, remain in ALL_RED with timer held at 1 until a pending bit is set, then advance on that cycle.
- pending[i]:
  - Set on any cycle req[i]=1, except while way i is in GREEN (those requests are ignored).
  - Cleared on the RED_AMBER->GREEN transition of way i.
  - Requests still latch while en=0.
  - Ignored when DEMAND_MODE=0.
- en=0: timer, phase and way frozen; lights unchanged.
- flash=1 (highest priority below rst):
  - Every way shows 3'b010 when flash_on=1, and 3'b000 otherwise.
  - flash_on=1 on the first flash cycle and toggles every FLASH_CYCLES cycles.
  - Phase is forced to ALL_RED with timer = ALLRED_CYCLES; way is retained.
  - On flash deassert, normal sequencing resumes with a full ALL_RED clearance, then next-way selection.
- Invariant: at most one way has amber or green lit outside flash mode. Verification asserts it every cycle.
- Full rotation period with DEMAND_MODE=0 and en=1: NUM_WAYS*(RA+G+A+AR) cycles.

Test Plan:
- NUM_WAYS=3, RA=2, G=4, A=3, AR=1, DEMAND=0; release rst -> 1 cycle all red, then way0 110 x2, 001 x4, 010 x3, all red x1, then way1. Way2 is followed by way0 again; period is 30 cycles.
- Same config; en=0 for 5 cycles mid-GREEN of way1 -> lights hold 001 on way1 for those 5 cycles, and GREEN totals 4 enabled cycles.
- DEMAND=1, NUM_WAYS=4; pulse req[2] for 1 cycle while idle in ALL_RED -> next cycle way=2 RED_AMBER. Then pulse req[0] and req[3] during way2 AMBER -> way3 is served, then way0, then idle all red.
- DEMAND=1; hold req[1]=1 throughout way1 GREEN, then drop it -> pending[1] not re-set and way1 not re-served.
- flash=1 for 10 cycles during way0 GREEN, FLASH_CYCLES=4 -> all ways 010 x4, 000 x4, 010 x2. After deassert, AR all-red cycles, then way1 RED_AMBER.
- Assert rst asynchronously mid-AMBER of way2 -> lights all 100 immediately without a clock edge. After release, sequencing restarts exactly as in the first scenario.

Source files
------------

// File: rtl/multi_way_traffic_lights.sv
// Junction controller sequencing NUM_WAYS approaches one at a time, with optional
// demand actuation, a run-enable hold and a flashing-amber fault/night mode.
module multi_way_traffic_lights #(
    parameter int NUM_WAYS      = 4,
    parameter int RA_CYCLES     = 2,
    parameter int GREEN_CYCLES  = 8,
    parameter int AMBER_CYCLES  = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int FLASH_CYCLES  = 4,
    parameter int DEMAND_MODE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        flash,
    input  logic [NUM_WAYS-1:0]         req,
    output logic [3*NUM_WAYS-1:0]       lights,
    output logic [$clog2(NUM_WAYS)-1:0] active_way,
    output logic [1:0]                  phase
);

    localparam int WAY_W   = $clog2(NUM_WAYS);
    localparam int MAX_RG  = (RA_CYCLES > GREEN_CYCLES) ? RA_CYCLES : GREEN_CYCLES;
    localparam int MAX_AA  = (AMBER_CYCLES > ALLRED_CYCLES) ? AMBER_CYCLES : ALLRED_CYCLES;
    localparam int MAX_CYC = (MAX_RG > MAX_AA) ? MAX_RG : MAX_AA;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int FLS_W   = $clog2(FLASH_CYCLES + 1);

    localparam logic [TMR_W-1:0] T_RA    = TMR_W'(RA_CYCLES);
    localparam logic [TMR_W-1:0] T_GREEN = TMR_W'(GREEN_CYCLES);
    localparam logic [TMR_W-1:0] T_AMBER = TMR_W'(AMBER_CYCLES);
    localparam logic [TMR_W-1:0] T_AR    = TMR_W'(ALLRED_CYCLES);
    localparam logic [TMR_W-1:0] T_ONE   = TMR_W'(1);
    localparam logic [FLS_W-1:0] F_LAST  = FLS_W'(FLASH_CYCLES - 1);

    typedef enum logic [1:0] {
        ALL_RED   = 2'd0,
        RED_AMBER = 2'd1,
        GREEN     = 2'd2,
        AMBER     = 2'd3
    } phase_t;

    phase_t              r_phase;
    logic [WAY_W-1:0]    r_way;
    logic [TMR_W-1:0]    r_timer;
    logic [NUM_WAYS-1:0] r_pending;
    logic [FLS_W-1:0]    r_flashCnt;
    logic                r_flashOn;
    logic                r_flashMode;

    phase_t              w_phaseNext;
    logic [WAY_W-1:0]    w_wayNext;
    logic [TMR_W-1:0]    w_timerNext;
    logic [NUM_WAYS-1:0] w_pendingNext;
    logic [FLS_W-1:0]    w_flashCntNext;
    logic                w_flashOnNext;
    logic                w_flashModeNext;

    logic [NUM_WAYS-1:0] w_reqSet;
    logic [NUM_WAYS-1:0] w_demand;
    logic [NUM_WAYS-1:0] w_servedClr;
    logic [WAY_W-1:0]    w_selWay;
    logic [WAY_W-1:0]    w_idx;
    logic                w_found;

    // Requests from the way currently in green are dropped; the demand set includes
    // this cycle's requests so an idle junction can start on the same edge.
    always_comb begin
        w_reqSet = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            w_reqSet[i] = req[i] && !(r_phase == GREEN && r_way == WAY_W'(i));
        w_demand = r_pending | w_reqSet;
        w_found  = 1'b0;
        w_selWay = r_way;
        w_idx    = '0;
        if (DEMAND_MODE == 0) begin
            w_found  = 1'b1;
            w_selWay = (r_way == WAY_W'(NUM_WAYS - 1)) ? '0 : r_way + 1'b1;
        end else begin
            for (int k = 1; k <= NUM_WAYS; k++) begin
                w_idx = WAY_W'((int'(r_way) + k) % NUM_WAYS);
                if (!w_found && w_demand[w_idx]) begin
                    w_found  = 1'b1;
                    w_selWay = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_phaseNext     = r_phase;
        w_wayNext       = r_way;
        w_timerNext     = r_timer;
        w_flashModeNext = r_flashMode;
        w_flashOnNext   = r_flashOn;
        w_flashCntNext  = r_flashCnt;
        w_servedClr     = '0;
        if (flash) begin
            w_flashModeNext = 1'b1;
            w_phaseNext     = ALL_RED;
            w_timerNext     = T_AR;
            if (!r_flashMode) begin
                w_flashOnNext  = 1'b1;
                w_flashCntNext = '0;
            end else if (r_flashCnt == F_LAST) begin
                w_flashOnNext  = ~r_flashOn;
                w_flashCntNext = '0;
            end else begin
                w_flashCntNext = r_flashCnt + 1'b1;
            end
        end else if (r_flashMode) begin
            // Leaving flash spends this edge re-arming a full all-red clearance.
            w_flashModeNext = 1'b0;
            w_flashOnNext   = 1'b0;
            w_flashCntNext  = '0;
        end else if (en) begin
            if (r_timer == T_ONE) begin
                case (r_phase)
                    ALL_RED: begin
                        if (w_found) begin
                            w_phaseNext = RED_AMBER;
                            w_wayNext   = w_selWay;
                            w_timerNext = T_RA;
                        end
                    end
                    RED_AMBER: begin
                        w_phaseNext        = GREEN;
                        w_timerNext        = T_GREEN;
                        w_servedClr[r_way] = 1'b1;
                    end
                    GREEN: begin
                        w_phaseNext = AMBER;
                        w_timerNext = T_AMBER;
                    end
                    AMBER: begin
                        w_phaseNext = ALL_RED;
                        w_timerNext = T_AR;
                    end
                endcase
            end else begin
                w_timerNext = r_timer - 1'b1;
            end
        end
        if (DEMAND_MODE == 0)
            w_pendingNext = '0;
        else
            w_pendingNext = (r_pending | w_reqSet) & ~w_servedClr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= ALL_RED;
            r_way       <= WAY_W'(NUM_WAYS - 1);
            r_timer     <= T_AR;
            r_pending   <= '0;
            r_flashCnt  <= '0;
            r_flashOn   <= 1'b0;
            r_flashMode <= 1'b0;
        end else begin
            r_phase     <= w_phaseNext;
            r_way       <= w_wayNext;
            r_timer     <= w_timerNext;
            r_pending   <= w_pendingNext;
            r_flashCnt  <= w_flashCntNext;
            r_flashOn   <= w_flashOnNext;
            r_flashMode <= w_flashModeNext;
        end
    end

    always_comb begin
        lights = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (r_flashMode)
                lights[3*i +: 3] = r_flashOn ? 3'b010 : 3'b000;
            else if (r_way == WAY_W'(i)) begin
                case (r_phase)
                    ALL_RED:   lights[3*i +: 3] = 3'b100;
                    RED_AMBER: lights[3*i +: 3] = 3'b110;
                    GREEN:     lights[3*i +: 3] = 3'b001;
                    AMBER:     lights[3*i +: 3] = 3'b010;
                endcase
            end else
                lights[3*i +: 3] = 3'b100;
        end
        active_way = r_way;
        phase      = r_phase;
    end

endmodule

// File: tb/tb_multi_way_traffic_lights.sv
// Bench for multi_way_traffic_lights: a fixed round-robin 3-way instance and a
// demand-actuated 4-way instance, checked cycle by cycle from an expectation queue.
`timescale 1ns/1ps
module tb_multi_way_traffic_lights;

    logic        clk = 1'b0;
    logic        rstA, enA, flashA;
    logic [2:0]  reqA;
    logic [8:0]  lightsA;
    logic [1:0]  wayA, phaseA;
    logic        rstB, enB, flashB;
    logic [3:0]  reqB;
    logic [11:0] lightsB;
    logic [1:0]  wayB, phaseB;

    int checks = 0;
    int errors = 0;
    logic monOn = 1'b0;

    logic [12:0] qA[$];
    logic [15:0] qB[$];

    always #5 clk = ~clk;

    multi_way_traffic_lights #(
        .NUM_WAYS(3), .RA_CYCLES(2), .GREEN_CYCLES(4), .AMBER_CYCLES(3),
        .ALLRED_CYCLES(1), .FLASH_CYCLES(4), .DEMAND_MODE(0)
    ) dutA (
        .clk(clk), .rst(rstA), .en(enA), .flash(flashA), .req(reqA),
        .lights(lightsA), .active_way(wayA), .phase(phaseA)
    );

    multi_way_traffic_lights #(
        .NUM_WAYS(4), .RA_CYCLES(2), .GREEN_CYCLES(4), .AMBER_CYCLES(3),
        .ALLRED_CYCLES(1), .FLASH_CYCLES(4), .DEMAND_MODE(1)
    ) dutB (
        .clk(clk), .rst(rstB), .en(enB), .flash(flashB), .req(reqB),
        .lights(lightsB), .active_way(wayB), .phase(phaseB)
    );

    // Offset within one served way: 0-1 red+amber, 2-5 green, 6-8 amber, 9 all-red.
    function automatic logic [2:0] offPat(input int o);
        if (o < 2)      return 3'b110;
        else if (o < 6) return 3'b001;
        else if (o < 9) return 3'b010;
        else            return 3'b100;
    endfunction

    function automatic logic [1:0] offPh(input int o);
        if (o < 2)      return 2'd1;
        else if (o < 6) return 2'd2;
        else if (o < 9) return 2'd3;
        else            return 2'd0;
    endfunction

    // Fixed rotation: n = number of enabled edges since reset release.
    function automatic logic [12:0] expA(input int n);
        logic [8:0] l = 9'b100100100;
        int w, o;
        if (n == 0) return {l, 2'd2, 2'd0};
        w = ((n - 1) / 10) % 3;
        o = (n - 1) % 10;
        l[3*w +: 3] = offPat(o);
        return {l, 2'(w), offPh(o)};
    endfunction

    function automatic logic [15:0] stB(input int w, input int o);
        logic [11:0] l = 12'b100100100100;
        l[3*w +: 3] = offPat(o);
        return {l, 2'(w), offPh(o)};
    endfunction

    function automatic int litCount(input logic [11:0] l);
        int n = 0;
        for (int i = 0; i < 4; i++)
            if (l[3*i+1] === 1'b1 || l[3*i] === 1'b1) n++;
        return n;
    endfunction

    // Outside flash, at most one approach may show amber or green.
    always @(negedge clk) begin
        if (monOn) begin
            if (!(lightsA == 9'b010010010 || lightsA == 9'b0)) begin
                checks++;
                if (litCount({3'b000, lightsA}) > 1) begin
                    errors++;
                    $display("[TB] FAIL invariantA: lights %b has %0d non-red ways, required <=1",
                             lightsA, litCount({3'b000, lightsA}));
                end
            end
            if (!(lightsB == 12'b010010010010 || lightsB == 12'b0)) begin
                checks++;
                if (litCount(lightsB) > 1) begin
                    errors++;
                    $display("[TB] FAIL invariantB: lights %b has %0d non-red ways, required <=1",
                             lightsB, litCount(lightsB));
                end
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rstA = 1'b1; rstB = 1'b1;
        enA = 1'b1; enB = 1'b1; flashA = 1'b0; flashB = 1'b0;
        reqA = '0; reqB = '0;
        @(negedge clk);
        @(negedge clk);
        rstA = 1'b0; rstB = 1'b0;
    endtask

    task automatic test_reset;
        logic [12:0] gotA;
        logic [15:0] gotB;
        @(negedge clk);
        rstA = 1'b1; rstB = 1'b1;
        #1;
        gotA = {lightsA, wayA, phaseA};
        checks++;
        if (gotA !== expA(0)) begin
            errors++;
            $display("[TB] FAIL resetA: got %b required %b", gotA, expA(0));
        end
        gotB = {lightsB, wayB, phaseB};
        checks++;
        if (gotB !== stB(3, 9)) begin
            errors++;
            $display("[TB] FAIL resetB: got %b required %b", gotB, stB(3, 9));
        end
    endtask

    task automatic test_fixed_rotation;
        logic [12:0] got, exp;
        do_reset();
        got = {lightsA, wayA, phaseA};
        checks++;
        if (got !== expA(0)) begin
            errors++;
            $display("[TB] FAIL rotation start: got %b required %b", got, expA(0));
        end
        for (int n = 1; n <= 32; n++) qA.push_back(expA(n));
        for (int n = 1; n <= 32; n++) begin
            @(posedge clk); #1;
            exp = qA.pop_front();
            got = {lightsA, wayA, phaseA};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL rotation cycle %0d: got %b required %b", n, got, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_en_hold;
        logic [12:0] got, exp;
        int m = 0;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            enA = (c >= 15 && c <= 19) ? 1'b0 : 1'b1;
            if (enA) m++;
            qA.push_back(expA(m));
            @(posedge clk); #1;
            exp = qA.pop_front();
            got = {lightsA, wayA, phaseA};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL en_hold cycle %0d: got %b required %b", c, got, exp);
            end
            @(negedge clk);
        end
        enA = 1'b1;
    endtask

    task automatic test_flash;
        logic [12:0] got, exp;
        logic [2:0]  pat;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            flashA = (c >= 4 && c <= 13);
            if (c <= 3)
                qA.push_back(expA(c));
            else if (c <= 13) begin
                pat = ((c - 4) < 4 || (c - 4) >= 8) ? 3'b010 : 3'b000;
                qA.push_back({{3{pat}}, 2'd0, 2'd0});
            end else
                qA.push_back(expA(10 + (c - 14)));
            @(posedge clk); #1;
            exp = qA.pop_front();
            got = {lightsA, wayA, phaseA};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL flash cycle %0d: got %b required %b", c, got, exp);
            end
            @(negedge clk);
        end
        flashA = 1'b0;
    endtask

    task automatic test_async_reset;
        logic [12:0] got, exp;
        do_reset();
        for (int n = 1; n <= 28; n++) begin
            qA.push_back(expA(n));
            @(posedge clk); #1;
            exp = qA.pop_front();
            got = {lightsA, wayA, phaseA};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL async_pre cycle %0d: got %b required %b", n, got, exp);
            end
            @(negedge clk);
        end
        #2 rstA = 1'b1;
        #1;
        got = {lightsA, wayA, phaseA};
        checks++;
        if (got !== expA(0)) begin
            errors++;
            $display("[TB] FAIL async_reset midcycle: got %b required %b", got, expA(0));
        end
        @(negedge clk);
        rstA = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            qA.push_back(expA(n));
            @(posedge clk); #1;
            exp = qA.pop_front();
            got = {lightsA, wayA, phaseA};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL async_restart cycle %0d: got %b required %b", n, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_demand;
        logic [15:0] got, exp;
        do_reset();
        for (int c = 1; c <= 35; c++) begin
            reqB = (c == 3) ? 4'b0100 : (c == 10) ? 4'b1001 : 4'b0000;
            if (c <= 2)       qB.push_back(stB(3, 9));
            else if (c <= 12) qB.push_back(stB(2, c - 3));
            else if (c <= 22) qB.push_back(stB(3, c - 13));
            else if (c <= 32) qB.push_back(stB(0, c - 23));
            else              qB.push_back(stB(0, 9));
            @(posedge clk); #1;
            exp = qB.pop_front();
            got = {lightsB, wayB, phaseB};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL demand cycle %0d: got %b required %b", c, got, exp);
            end
            @(negedge clk);
        end
        reqB = '0;
    endtask

    task automatic test_demand_hold;
        logic [15:0] got, exp;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            reqB = (c == 1 || (c >= 4 && c <= 7)) ? 4'b0010 : 4'b0000;
            if (c <= 10) qB.push_back(stB(1, c - 1));
            else         qB.push_back(stB(1, 9));
            @(posedge clk); #1;
            exp = qB.pop_front();
            got = {lightsB, wayB, phaseB};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL demand_hold cycle %0d: got %b required %b", c, got, exp);
            end
            @(negedge clk);
        end
        reqB = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstA = 1'b0; rstB = 1'b0;
        enA = 1'b1; enB = 1'b1;
        flashA = 1'b0; flashB = 1'b0;
        reqA = '0; reqB = '0;
        test_reset();
        monOn = 1'b1;
        test_fixed_rotation();
        test_en_hold();
        test_flash();
        test_async_reset();
        test_demand();
        test_demand_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
